// File: rtl/spi_pwm_pkg.sv
// rtl/spi_pwm_pkg.sv - shared constants and types for spi_pwm_multichannel
// Contents: register map base addresses, frame FSM state enum, PWM period limit.
package spi_pwm_pkg;

    localparam int EN_OUT_BASE   = 'h00;
    localparam int EN_PWM_BASE   = 'h04;
    localparam int PRESCALE_ADDR = 'h08;
    localparam int DUTY_BASE     = 'h10;

    // Period counter runs 0..254, giving 255 ticks per PWM period.
    localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } frame_state_t;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow duty, compare and enable muxing
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   period_cnt   shared period counter (0..254)
//   tick         prescaler wrap strobe
//   period_wrap  period counter sits at its last value
//   duty         programmed duty (loaded into the shadow at period wrap)
//   en_out       channel output enable
//   en_pwm       1 = PWM, 0 = static high (when en_out)
//   pwm_out      registered channel output
module pwm_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_cnt,
    input  logic       tick,
    input  logic       period_wrap,
    input  logic [7:0] duty,
    input  logic       en_out,
    input  logic       en_pwm,
    output logic       pwm_out
);

    logic [7:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= 8'h00;
            pwm_out <= 1'b0;
        end else begin
            // The shadow only changes on the 254->0 step, so a period always
            // completes with the duty it started with.
            if (tick && period_wrap) begin
                shadow <= duty;
            end
            // 0xFF gives constant high because the counter never reaches 255.
            pwm_out <= en_out & (~en_pwm | (period_cnt < shadow));
        end
    end

endmodule

// File: rtl/spi_pwm_multichannel.sv
// rtl/spi_pwm_multichannel.sv - SPI mode-0 register target driving a bank of PWM channels
// Optional feature macro: SPI_READBACK_EN (read frames return register data on cipo).
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   sclk, copi, ncs  SPI target inputs, asynchronous to clk
//   cipo        SPI read-back data (0 while ncs high, or always 0 without read-back)
//   pwm_out     CHANNELS registered channel outputs
//   frame_err   one-cycle pulse when a frame is aborted after at least one bit
module spi_pwm_multichannel
    import spi_pwm_pkg::*;
#(
    parameter int         CHANNELS         = 16,
    parameter logic [7:0] DEFAULT_PRESCALE = 8'd0,
    parameter int         SYNC_STAGES      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                copi,
    input  logic                ncs,
    output logic                cipo,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_err
);

    localparam int BYTES = CHANNELS / 8;

    // Synchronisers reset to 0: a frame cut by rst leaves ncs low, and with
    // no falling edge seen the remainder of that frame is ignored.
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic sclk_prev, ncs_prev;
    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;

    frame_state_t state, state_next;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic        shift_en, commit, abort_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        commit     = 1'b0;
        abort_err  = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) state_next = ADDR;
            end
            ADDR, DATA: begin
                if (ncs_rise) begin
                    state_next = IDLE;
                    abort_err  = (bit_cnt != 5'd0);
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 5'd7)       state_next = DATA;
                    else if (bit_cnt == 5'd15) state_next = DONE;
                end
            end
            DONE: begin
                if (ncs_rise) begin
                    state_next = IDLE;
                    commit     = rx_shift[15];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 5'd0;
            rx_shift  <= 16'h0000;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort_err;
            if (state == IDLE && ncs_fall) begin
                bit_cnt <= 5'd0;
            end else if (shift_en) begin
                bit_cnt  <= bit_cnt + 5'd1;
                rx_shift <= {rx_shift[14:0], copi_s};
            end
        end
    end

    logic [CHANNELS-1:0] en_out, en_pwm;
    logic [7:0]          prescale;
    logic [7:0]          duty [CHANNELS];
    logic [6:0]          waddr;
    logic [7:0]          wdata;

    assign waddr = rx_shift[14:8];
    assign wdata = rx_shift[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out   <= '0;
            en_pwm   <= '0;
            prescale <= DEFAULT_PRESCALE;
            for (int n = 0; n < CHANNELS; n++) duty[n] <= 8'h00;
        end else if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (int'(waddr) == EN_OUT_BASE + b) en_out[b*8 +: 8] <= wdata;
                if (int'(waddr) == EN_PWM_BASE + b) en_pwm[b*8 +: 8] <= wdata;
            end
            if (int'(waddr) == PRESCALE_ADDR) prescale <= wdata;
            for (int n = 0; n < CHANNELS; n++) begin
                if (int'(waddr) == DUTY_BASE + n) duty[n] <= wdata;
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [6:0] raddr;
    logic [7:0] rdata, tx_shift;

    assign sclk_fall = ~sclk_s & sclk_prev;
    // On the 8th rising edge the address is the 7 bits after R/W: six
    // already shifted in plus the bit arriving now.
    assign raddr     = {rx_shift[5:0], copi_s};

    always_comb begin
        rdata = 8'h00;
        for (int b = 0; b < BYTES; b++) begin
            if (int'(raddr) == EN_OUT_BASE + b) rdata = en_out[b*8 +: 8];
            if (int'(raddr) == EN_PWM_BASE + b) rdata = en_pwm[b*8 +: 8];
        end
        if (int'(raddr) == PRESCALE_ADDR) rdata = prescale;
        for (int n = 0; n < CHANNELS; n++) begin
            if (int'(raddr) == DUTY_BASE + n) rdata = duty[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= 8'h00;
            cipo     <= 1'b0;
        end else begin
            if (state == ADDR && shift_en && bit_cnt == 5'd7) begin
                // rx_shift[6] is the R/W bit at this point; writes send zeros.
                tx_shift <= rx_shift[6] ? 8'h00 : rdata;
            end else if (state == DATA && sclk_fall) begin
                cipo     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (ncs_s) cipo <= 1'b0;
        end
    end
`else
    assign cipo = 1'b0;
`endif

    logic [7:0] pre_cnt, period_cnt;
    logic       tick, period_wrap;

    // >= lets a freshly lowered PRESCALE wrap at once instead of running to 255.
    assign tick        = (pre_cnt >= prescale);
    assign period_wrap = (period_cnt == PWM_PERIOD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= 8'h00;
            period_cnt <= 8'h00;
        end else begin
            pre_cnt <= tick ? 8'h00 : pre_cnt + 8'h01;
            if (tick) period_cnt <= period_wrap ? 8'h00 : period_cnt + 8'h01;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        pwm_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .period_cnt (period_cnt),
            .tick       (tick),
            .period_wrap(period_wrap),
            .duty       (duty[n]),
            .en_out     (en_out[n]),
            .en_pwm     (en_pwm[n]),
            .pwm_out    (pwm_out[n])
        );
    end

endmodule

// File: tb/tb_spi_pwm_multichannel.sv
// tb/tb_spi_pwm_multichannel.sv - self-checking bench for spi_pwm_multichannel
module tb_spi_pwm_multichannel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        copi = 1'b0;
    logic        ncs = 1'b1;
    logic        cipo;
    logic [15:0] pwm_out;
    logic        frame_err;

    spi_pwm_multichannel dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .cipo     (cipo),
        .pwm_out  (pwm_out),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [15:0] frame;
        logic [15:0] exp_pwm;
    } vec_t;

    typedef struct {
        int hi;
        int period;
    } pulse_t;

    vec_t        vecs [11];
    pulse_t      exp_q [$];
    logic [7:0]  rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int err_cycles = 0;
    always @(negedge clk) if (frame_err === 1'b1) err_cycles++;

    // Pulse monitor: on each rising edge of the watched channel it closes the
    // previous full period and compares it with the next queued expectation.
    int   mon_ch = 0;
    bit   mon_en = 0;
    logic mon_prev = 1'b0;
    logic mon_cur;
    int   hi_run = 0, lo_run = 0, hi_last = 0;
    bit   started = 0, have_hi = 0;
    pulse_t mon_e;

    always @(negedge clk) begin
        mon_cur = pwm_out[mon_ch];
        if (!mon_en) begin
            started = 0;
            have_hi = 0;
        end else if (mon_cur && !mon_prev) begin
            if (have_hi && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_high", 32'(hi_last), 32'(mon_e.hi));
                check("pulse_period", 32'(hi_last + lo_run), 32'(mon_e.period));
            end
            started = 1;
            have_hi = 0;
            hi_run  = 1;
        end else if (mon_cur) begin
            hi_run++;
        end else if (mon_prev) begin
            if (started) begin
                hi_last = hi_run;
                have_hi = 1;
            end
            lo_run = 1;
        end else begin
            lo_run++;
        end
        mon_prev = mon_cur;
    end

    task automatic wait_exp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: timeout with %0d pulses outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One SPI mode-0 frame, sclk period 10 clk; rst pulses before bit rst_at.
    task automatic spi_frame(input logic [15:0] frame, input int nbits, input int rst_at,
                             output logic [7:0] rd);
        rd = 8'h00;
        @(posedge clk);
        ncs = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(posedge clk);
                rst = 1'b0;
            end
            copi = frame[15-i];
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (i >= 8) rd[15-i] = cipo;
            @(posedge clk);
            sclk = 1'b1;
            repeat (5) @(posedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(posedge clk);
        ncs = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic spi_write(input logic [15:0] frame);
        logic [7:0] unused_rd;
        spi_frame(frame, 16, -1, unused_rd);
    endtask

    task automatic spi_read_check(input logic [6:0] addr);
        logic [7:0] rd;
        logic [7:0] exp;
        spi_frame({1'b0, addr, 8'h00}, 16, -1, rd);
        exp = rd_q.pop_front();
        check("readback", {24'h0, rd}, {24'h0, exp});
    endtask

    int cnt;
    int err_before;

    initial begin
        vecs[0]  = '{16'h80FF, 16'h00FF};
        vecs[1]  = '{16'h8400, 16'h00FF};
        vecs[2]  = '{16'h81A5, 16'hA5FF};
        vecs[3]  = '{16'h82FF, 16'hA5FF};
        vecs[4]  = '{16'h85F0, 16'h05FF};
        vecs[5]  = '{16'h8500, 16'hA5FF};
        vecs[6]  = '{16'h0001, 16'hA5FF};
        vecs[7]  = '{16'h800F, 16'hA50F};
        vecs[8]  = '{16'h8100, 16'h000F};
        vecs[9]  = '{16'hFFFF, 16'h000F};
        vecs[10] = '{16'h8602, 16'h000F};

        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pwm_out", {16'h0, pwm_out}, 32'h0);
        check("reset_cipo", {31'h0, cipo}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);

        for (int v = 0; v < 11; v++) begin
            spi_write(vecs[v].frame);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_pwm_out", v), {16'h0, pwm_out}, {16'h0, vecs[v].exp_pwm});
        end

        // ch0 PWM at duty 0x80, prescale 0: 128 high of 255.
        spi_write(16'h8401);
        spi_write(16'h9080);
        mon_ch = 0;
        exp_q.push_back('{128, 255});
        exp_q.push_back('{128, 255});
        mon_en = 1;
        wait_exp("ch0_duty80", 3000);
        mon_en = 0;

        spi_write(16'h90FF);
        repeat (600) @(negedge clk);
        cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (pwm_out[0] !== 1'b1) cnt++;
        end
        check("duty_ff_low_cycles", 32'(cnt), 32'h0);
        check("duty_ff_low_nibble", {28'h0, pwm_out[3:0]}, 32'hF);

        spi_write(16'h9000);
        repeat (600) @(negedge clk);
        cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (pwm_out[0] !== 1'b0) cnt++;
        end
        check("duty_00_high_cycles", 32'(cnt), 32'h0);
        check("duty_00_low_nibble", {28'h0, pwm_out[3:0]}, 32'hE);

        // ch3 at 0xC0, prescale 3 (4 clk per tick); rewrite to 0x40 mid-period.
        spi_write(16'h8409);
        spi_write(16'h8803);
        spi_write(16'h93C0);
        mon_ch = 3;
        exp_q.push_back('{768, 1020});
        mon_en = 1;
        wait_exp("ch3_dutyC0", 6000);
        spi_write(16'h9340);
        exp_q.push_back('{768, 1020});
        exp_q.push_back('{256, 1020});
        wait_exp("ch3_midperiod", 6000);

        // Aborted write to PRESCALE after 11 bits: one error pulse, period unchanged.
        err_before = err_cycles;
        begin
            logic [7:0] unused_rd;
            spi_frame(16'h8877, 11, -1, unused_rd);
        end
        check("abort_frame_err_cycles", 32'(err_cycles - err_before), 32'h1);
        exp_q.push_back('{256, 1020});
        wait_exp("abort_prescale_kept", 6000);
        mon_en = 0;

        spi_write(16'h905A);
`ifdef SPI_READBACK_EN
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'h00);
        rd_q.push_back(8'h03);
        rd_q.push_back(8'h0F);
`else
        repeat (4) rd_q.push_back(8'h00);
`endif
        spi_read_check(7'h10);
        spi_read_check(7'h7F);
        spi_read_check(7'h08);
        spi_read_check(7'h00);
        @(negedge clk);
        check("cipo_idle", {31'h0, cipo}, 32'h0);

        // rst mid-frame: no write, no error pulse; prescale stays at default 0.
        err_before = err_cycles;
        begin
            logic [7:0] unused_rd;
            spi_frame(16'h8801, 16, 11, unused_rd);
        end
        check("rst_mid_frame_err", 32'(err_cycles - err_before), 32'h0);
        check("rst_mid_frame_pwm", {16'h0, pwm_out}, 32'h0);
        spi_write(16'h8001);
        spi_write(16'h8401);
        spi_write(16'h9080);
        mon_ch = 0;
        exp_q.push_back('{128, 255});
        mon_en = 1;
        wait_exp("rst_prescale_default", 3000);
        mon_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_pwm_multichannel.md
# spi_pwm_multichannel

Parametrised successor to the onboarding SPI + PWM pair. A mode-0 SPI target writes and reads a byte-wide register map holding per-channel output enables, PWM enables, per-channel duty cycles and a shared prescaler. A bank of `CHANNELS` PWM outputs is driven from that map. Duty updates are double-buffered so each PWM period is glitch-free. The block sits directly behind the chip's dedicated pins, one instance per design.

## Interface
- `CHANNELS`, 16, PWM channel count; multiple of 8, range 8..32.
- `DEFAULT_PRESCALE`, 0, reset value of the PRESCALE register (8 bits).
- `SYNC_STAGES`, 2, synchroniser depth on `sclk`/`copi`/`ncs`; minimum 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `copi`  in  1  SPI data in.
- `ncs`  in  1  SPI chip select, active-low.
- `cipo`  out  1  SPI data out (read-back).
- `pwm_out`  out  `CHANNELS`  channel outputs.
- `frame_err`  out  1  one-cycle pulse on an aborted frame.

## Operation
- Register map, all 8-bit:
  - EN_OUT: bytes 0x00..0x03 (`CHANNELS`/8 used).
  - EN_PWM: bytes 0x04..0x07.
  - PRESCALE: 0x08.
  - DUTY[n]: 0x10+n.
  - Writes to unused or undefined addresses are ignored. Reads of them return 0x00.
- Frame format: 16 bits, MSB first, sampled on synchronised `sclk` rising edge.
  - Bit 15: 1 = write, 0 = read.
  - Bits 14:8: address.
  - Bits 7:0: write data (ignored on read).
- Frame control FSM, states IDLE, ADDR, DATA, DONE:
  - `ncs` fall → ADDR, bit counter cleared.
  - 8 bits received → DATA. On a read, the addressed register is latched into the TX shift register here.
  - 16 bits received → DONE. Further `sclk` edges are ignored.
  - `ncs` rise in DONE with a write commits the write, then → IDLE.
  - `ncs` rise in ADDR/DATA: frame discarded, `frame_err` pulses if at least one bit was received, → IDLE.
- Channel output n:
  - EN_OUT[n]=0 → 0.
  - EN_OUT[n]=1, EN_PWM[n]=0 → 1.
  - Both set → PWM.
- PWM:
  - A prescale counter counts 0..PRESCALE. Its wrap asserts `tick`.
  - The shared 8-bit period counter advances on `tick` and counts 0..254, so the period is 255 ticks.
  - Channel high while counter < shadow duty. Shadow duty 0xFF → constant high. 0x00 → constant low.
- Duty double buffering:
  - SPI writes land in DUTY[n].
  - All shadows load from DUTY on the tick where the period counter wraps 254→0.
- PRESCALE write takes effect immediately. The prescale counter compares with ≥, so a reduced value wraps on the next cycle instead of running through 255.

## Timing
- Reset values:
  - All registers 0 except PRESCALE = `DEFAULT_PRESCALE`.
  - Shadows, counters, `pwm_out`, `cipo`, `frame_err` all 0.
  - FSM in IDLE.
- Input latency: `SYNC_STAGES` cycles, plus 1 cycle of edge detect.
- Write commit: register updated `SYNC_STAGES`+1 cycles after `ncs` rises.
  - EN_OUT/EN_PWM reach `pwm_out` on the following cycle (registered outputs).
  - Duty changes appear at the next period boundary.
- Read-back: TX data bit 7 drives `cipo` on the first synchronised `sclk` falling edge after bit 8, then one bit per falling edge. `cipo` = 0 whenever `ncs` is high.
- `sclk` frequency ≤ `clk`/(2·(`SYNC_STAGES`+2)). Behaviour above this is undefined.
- Simultaneous commit and period wrap: the shadow loads the pre-write value, and the new duty applies one period later.
- `rst` mid-frame aborts the frame with no commit and no `frame_err`.

## Configuration
- `SPI_READBACK_EN`:
  - Defined: read frames return register data on `cipo`.
  - Undefined: TX shift register and read mux are absent, `cipo` is tied 0, and read frames complete silently with no effect.

## Structure
- Package `spi_pwm_pkg`:
  - Address constants (EN_OUT_BASE, EN_PWM_BASE, PRESCALE_ADDR, DUTY_BASE).
  - FSM state enum.
  - PWM_PERIOD_MAX = 254.
- Sub-module `pwm_channel`: holds the shadow duty, the compare and the enable muxing. It is instantiated `CHANNELS` times, fed by the shared period counter, `tick` and the wrap strobe.

## Test plan
- Reset, then write 0x00←0xFF and 0x04←0x00 → `pwm_out`[7:0]=0xFF static, upper channels 0.
- Enable ch0 PWM, DUTY[0]=0x80, PRESCALE=0 → ch0 high exactly 128 of every 255 `clk` cycles.
- DUTY[0]=0xFF → constant high. DUTY[0]=0x00 → constant low, with no single-cycle glitches.
- Write DUTY[3]=0x40 mid-period while it runs at 0xC0 → current period keeps 192 high ticks, next period 64.
- Read 0x10 after writing 0x5A (`SPI_READBACK_EN`) → `cipo` shifts 0,1,0,1,1,0,1,0. Read 0x7F → 0x00.
- Raise `ncs` after 11 bits of a write to 0x08 → PRESCALE unchanged, `frame_err` pulses once. Assert `rst` mid-frame → no write, no pulse.
